// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/periodic reload, pause, abort and near-expiry warning
// Ports:
//   clock_50   in  1      system clock
//   reset      in  1      synchronous, active-high
//   load_value in  WIDTH  count loaded on an accepted start
//   start      in  1      load and run (retriggers when already running)
//   periodic   in  1      sampled with start; auto-reload on expiry
//   pause      in  1      level; holds the count
//   abort      in  1      return to idle without an expiry pulse
//   ack        in  1      leaves DONE in one-shot mode
//   remaining  out WIDTH  current count
//   busy       out 1      running or held
//   done       out 1      one-shot expiry reached, awaiting ack
//   expired    out 1      one-cycle pulse when the count reaches zero
//   warn       out 1      busy with a nonzero count at or below WARN_CYCLES
module countdown_timer #(
  parameter int WIDTH       = 28,
  parameter int WARN_CYCLES = 100_000_000
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  input  logic             ack,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             expired,
  output logic             warn
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] reload, reload_n, remaining_n;
  logic per, per_n, expired_n;
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      reload    <= '0;
      per       <= 1'b0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      reload    <= reload_n;
      per       <= per_n;
      expired   <= expired_n;
      busy      <= state_n == RUN || state_n == HOLD;
      done      <= state_n == DONE;
    end
  end
  // A periodic timer spends one cycle at zero before reloading, so pulses are load+1 cycles apart.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    reload_n    = reload;
    per_n       = per;
    expired_n   = 1'b0;
    if (abort) begin
      state_n     = IDLE;
      remaining_n = '0;
    end else if (start) begin
      if (load_value != '0) begin
        remaining_n = load_value;
        reload_n    = load_value;
        per_n       = periodic;
        state_n     = pause ? HOLD : RUN;
      end
    end else if (state == RUN && !pause) begin
      if (remaining == WIDTH'(1)) begin
        remaining_n = '0;
        expired_n   = 1'b1;
        state_n     = per ? RUN : DONE;
      end else if (remaining == '0) begin
        remaining_n = per ? reload : '0;
        state_n     = per ? RUN : DONE;
      end else begin
        remaining_n = remaining - WIDTH'(1);
      end
    end else if (state == RUN) begin
      state_n = HOLD;
    end else if (state == HOLD && !pause) begin
      state_n = RUN;
    end else if (state == DONE && ack) begin
      state_n = IDLE;
    end
  end
  assign warn = busy && remaining != '0 && 64'(remaining) <= 64'(WARN_CYCLES);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus random stimulus checked against a behavioural timer model
module tb_countdown_timer;
  localparam int W = 8;
  localparam int WARN = 4;
  logic clock_50 = 0;
  logic reset = 1, start = 0, periodic = 0, pause = 0, abort = 0, ack = 0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] remaining;
  logic busy, done, expired, warn;
  int n_chk = 0, n_fail = 0, pulses = 0;
  bit m_run, m_hold, m_done, m_per, m_exp;
  int m_rem, m_rel;

  countdown_timer #(.WIDTH(W), .WARN_CYCLES(WARN)) dut (
    .clock_50(clock_50), .reset(reset), .load_value(load_value), .start(start),
    .periodic(periodic), .pause(pause), .abort(abort), .ack(ack),
    .remaining(remaining), .busy(busy), .done(done), .expired(expired), .warn(warn)
  );

  always #5 clock_50 = ~clock_50;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function void model_step();
    m_exp = 0;
    if (reset) begin
      {m_run, m_hold, m_done, m_per} = '0;
      m_rem = 0;
      m_rel = 0;
    end else if (abort) begin
      {m_run, m_hold, m_done} = '0;
      m_rem = 0;
    end else if (start) begin
      if (load_value != 0) begin
        m_rem = int'(load_value);
        m_rel = m_rem;
        m_per = periodic;
        m_run = !pause;
        m_hold = pause;
        m_done = 0;
      end
    end else if (m_run && pause) begin
      m_run = 0;
      m_hold = 1;
    end else if (m_run) begin
      if (m_rem == 0) m_rem = m_rel;
      else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_exp = 1;
          if (!m_per) begin
            m_run = 0;
            m_done = 1;
          end
        end
      end
    end else if (m_hold && !pause) begin
      m_hold = 0;
      m_run = 1;
    end else if (m_done && ack) m_done = 0;
  endfunction

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_50);
      model_step();
      #1;
      check("remaining", 32'(remaining), 32'(m_rem));
      check("busy", 32'(busy), 32'(m_run || m_hold));
      check("done", 32'(done), 32'(m_done));
      check("expired", 32'(expired), 32'(m_exp));
      check("warn", 32'(warn), 32'((m_run || m_hold) && m_rem != 0 && m_rem <= WARN));
      if (expired) pulses++;
    end
  endtask

  task automatic go(int n, bit p = 0);
    load_value = W'(n);
    periodic = p;
    start = 1;
    tick();
    start = 0;
    periodic = 0;
  endtask

  initial begin
    tick(2);
    check("reset_remaining", 32'(remaining), 0);
    check("reset_flags", {busy, done, expired, warn}, 0);
    reset = 0;
    tick();
    pulses = 0;
    go(5);
    check("t1_busy", 32'(busy), 1);
    check("t1_load", 32'(remaining), 5);
    tick(8);
    check("t1_pulses", pulses, 1);
    check("t1_done", 32'(done), 1);
    ack = 1;
    tick();
    ack = 0;
    check("t1_idle", {busy, done}, 0);
    pulses = 0;
    go(3, 1);
    tick(20);
    check("t2_pulses", pulses, 5);
    check("t2_busy", 32'(busy), 1);
    abort = 1;
    tick();
    abort = 0;
    tick(8);
    check("t2_after_abort", pulses, 5);
    check("t2_idle", {busy, remaining}, 0);
    go(10);
    tick(4);
    check("t3_at6", 32'(remaining), 6);
    pause = 1;
    tick(4);
    pause = 0;
    check("t3_held", 32'(remaining), 6);
    tick(12);
    check("t3_done", 32'(done), 1);
    pulses = 0;
    go(8);
    tick(6);
    check("t4_at2", 32'(remaining), 2);
    go(20);
    check("t4_reload", 32'(remaining), 20);
    tick(19);
    check("t4_no_pulse", pulses, 0);
    tick();
    check("t4_pulse", pulses, 1);
    ack = 1;
    tick();
    ack = 0;
    go(0);
    check("t5_zero_load", {busy, done}, 0);
    load_value = 5;
    start = 1;
    abort = 1;
    tick();
    {start, abort} = '0;
    check("t5_start_abort", 32'(busy), 0);
    go(9);
    tick(3);
    reset = 1;
    tick();
    reset = 0;
    check("t5_reset", {busy, done, expired, warn, remaining}, 0);
    go(10);
    tick(14);
    check("t6_done_warn", {done, warn}, 2);
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(15) == 0);
      load_value = W'($urandom_range(12));
      periodic = 1'($urandom);
      pause = ($urandom_range(7) == 0);
      abort = ($urandom_range(63) == 0);
      ack = ($urandom_range(3) == 0);
      reset = ($urandom_range(255) == 0);
      tick();
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
